operand_stream_bank: RTL and testbench
======================================

# operand_stream_bank

Parametrised operand buffer and streamer for the MAC-array matrix multiplier: accepts W (row_w × col_w) and X (row_x × col_x) elements over a valid/ready input stream, then streams one W column and one X row per cycle into a MAX_DIM × MAX_DIM MAC grid. It generates per-cell clear and load strobes and signals completion. It generalises the fixed 3×3, 4-bit operand bank with the following additions:
- configurable data width and array size
- input backpressure
- stream stall
- dimension checking

## Interface
- DW, 4, operand width in bits
- MAX_DIM, 3, maximum rows/cols of either matrix and side of the MAC grid
- DIMW, $clog2(MAX_DIM+1), width of dimension inputs (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- clear  in  1  reset, asynchronous, active-high
- start  in  1  begin a new load/stream job (sampled in IDLE only)
- row_w, col_w, row_x, col_x  in  DIMW each  matrix dimensions, sampled on accepted start
- data_in  in  DW  operand element
- in_valid  in  1  data_in valid
- in_ready  out  1  block accepts data_in this cycle
- hold  in  1  stall streaming
- w_out  out  MAX_DIM*DW  W column k; lane i = W[i][k]
- x_out  out  MAX_DIM*DW  X row k; lane j = X[k][j]
- ld_mac  out  MAX_DIM*MAX_DIM  per-cell accumulate strobe; bit i*MAX_DIM+j
- clear_mac  out  MAX_DIM*MAX_DIM  per-cell accumulator clear; same indexing
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end
- dim_err  out  1  last start rejected; sticky until next start

## Operation
- FSM states: IDLE, LOAD_W, LOAD_X, CLR, STREAM, DONE.
- IDLE, start=1:
  - Latch all four dimensions.
  - If any dimension is 0, any exceeds MAX_DIM, or col_w≠row_x: set dim_err, stay IDLE.
  - Otherwise clear dim_err and go to LOAD_W.
- start is ignored outside IDLE.
- LOAD_W:
  - in_ready=1; a beat is accepted when in_valid&in_ready.
  - Elements arrive row-major. Each is written to W[r][c], stored at fixed stride r*MAX_DIM+c (no multiplier).
  - c increments and wraps at col_w; r increments on the wrap.
  - The beat writing W[row_w-1][col_w-1] moves the FSM to LOAD_X, with r/c reset to 0.
- LOAD_X: identical to LOAD_W with row_x/col_x. The last beat moves the FSM to CLR.
- CLR: one cycle. clear_mac bit (i,j)=1 for i<row_w and j<col_x, 0 elsewhere. in_ready=0. Next state is STREAM with k=0.
- STREAM:
  - If hold=0: w_out lane i = W[i][k] for i<row_w, else 0. x_out lane j = X[k][j] for j<col_x, else 0. ld_mac(i,j)=1 for active cells. k increments.
  - After the beat with k=col_w-1, go to DONE.
  - If hold=1: w_out=0, x_out=0, ld_mac=0, k holds.
- DONE: done=1 for one cycle, then IDLE. Stored matrices are retained until overwritten or clear.
- Lanes and cells outside the active dimensions always output 0 and never strobe.
- clear at any time, including mid-load or mid-stream:
  - FSM to IDLE; all counters, stored elements and latched dimensions to 0.
  - dim_err to 0.
  - A partially loaded job is discarded.

## Timing
- Reset values: in_ready=0, w_out=0, x_out=0, ld_mac=0, clear_mac=0, busy=0, done=0, dim_err=0.
- Decode timing:
  - w_out, x_out, ld_mac and clear_mac are decoded from registered state and counters, and are valid in the same cycle as the corresponding state/k.
  - in_ready is decoded from state only, with no combinational path from in_valid.
- Accepted start at edge t: busy=1 from t+1, and in_ready=1 from t+1.
- Load takes exactly row_w*col_w + row_x*col_x accepted beats. in_valid gaps extend it cycle for cycle.
- CLR occupies the cycle after the final X beat.
- STREAM takes col_w non-held cycles. done is asserted the cycle after the last stream beat.
- Minimum job length with no gaps or holds: start edge, then row_w*col_w + row_x*col_x + 1 + col_w + 1 cycles to return to IDLE.
- dim_err updates the cycle after the start edge. busy stays 0 on a rejected start.

## Test plan
- 3×3 by 3×3, W=1..9, X=9..1, no gaps:
  - in_ready high for 18 beats, clear_mac=9'h1FF for 1 cycle.
  - Stream k=0 gives w_out lanes {1,4,7} and x_out lanes {9,8,7}, ld_mac=9'h1FF.
  - done at cycle 22 after start.
- 2×3 by 3×1 (DW=4):
  - Active cells only (0,0) and (1,0): ld_mac=9'b000001001.
  - Lane 2 of w_out and lanes 1–2 of x_out read 0 for all 3 stream beats.
- hold asserted on stream beat k=1 for 2 cycles: outputs and ld_mac are 0 during hold; k=1 data resumes unchanged; done is delayed by exactly 2 cycles.
- in_valid toggled 1/0 every cycle during load: only valid beats are written; the final stream data equals the gap-free case.
- Dimension errors:
  - start with col_w=2, row_x=3 gives dim_err=1, busy=0, in_ready=0.
  - start with row_w=4 (MAX_DIM=3) gives dim_err=1.
  - A following valid start clears dim_err.
- clear asserted after 5 of 9 W beats: the next cycle is IDLE with all outputs 0. A new job loaded afterwards streams only new data, with no stale elements.

Source files
------------

// File: rtl/operand_stream_bank_if.sv
// operand_stream_bank_if: operand load stream, MAC-grid operand lanes/strobes and job status.
interface operand_stream_bank_if #(parameter int DW = 4, parameter int MAX_DIM = 3);
  localparam int DIMW = $clog2(MAX_DIM + 1);
  logic                       start;
  logic [DIMW-1:0]            row_w, col_w, row_x, col_x;
  logic [DW-1:0]              data_in;
  logic                       in_valid, in_ready, hold;
  logic [MAX_DIM*DW-1:0]      w_out, x_out;
  logic [MAX_DIM*MAX_DIM-1:0] ld_mac, clear_mac;
  logic                       busy, done, dim_err;
  modport master (
    output start, row_w, col_w, row_x, col_x, data_in, in_valid, hold,
    input  in_ready, w_out, x_out, ld_mac, clear_mac, busy, done, dim_err
  );
  modport slave (
    input  start, row_w, col_w, row_x, col_x, data_in, in_valid, hold,
    output in_ready, w_out, x_out, ld_mac, clear_mac, busy, done, dim_err
  );
endinterface

// File: rtl/operand_stream_bank.sv
// operand_stream_bank: buffers W and X matrices from a valid/ready stream and
// streams one W column / X row per cycle into a MAX_DIM x MAX_DIM MAC grid.
module operand_stream_bank #(
  parameter int DW      = 4,
  parameter int MAX_DIM = 3
) (
  input logic                  clk,
  input logic                  clear,
  operand_stream_bank_if.slave bus
);
  localparam int DIMW = $clog2(MAX_DIM + 1);
  localparam int N    = MAX_DIM * MAX_DIM;
  localparam int AW   = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, CLR, STREAM, DONE} state_t;
  state_t          state_q, state_d;
  logic [DIMW-1:0] rw_q, rw_d, cw_q, cw_d, rx_q, rx_d, cx_q, cx_d;
  logic [DIMW-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
  logic [AW-1:0]   base_q, base_d, kb_q, kb_d;
  logic            dim_err_q, dim_err_d;
  logic [DW-1:0]   w_q [N];
  logic [DW-1:0]   x_q [N];
  logic            beat, bad, last_c, last_r, streaming;
  logic [DIMW-1:0] rows, cols;
  logic [AW-1:0]   addr;
  assign beat      = bus.in_valid && bus.in_ready;
  assign rows      = (state_q == LOAD_W) ? rw_q : rx_q;
  assign cols      = (state_q == LOAD_W) ? cw_q : cx_q;
  assign last_c    = c_q == cols - 1'b1;
  assign last_r    = r_q == rows - 1'b1;
  // Row base advances by MAX_DIM on each column wrap, giving the r*MAX_DIM+c stride without a multiplier.
  assign addr      = base_q + AW'(c_q);
  assign streaming = (state_q == STREAM) && !bus.hold;
  assign bad = (bus.row_w == '0) || (bus.col_w == '0) || (bus.row_x == '0) || (bus.col_x == '0) ||
               (bus.row_w > DIMW'(MAX_DIM)) || (bus.col_w > DIMW'(MAX_DIM)) ||
               (bus.row_x > DIMW'(MAX_DIM)) || (bus.col_x > DIMW'(MAX_DIM)) ||
               (bus.col_w != bus.row_x);
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    cw_d      = cw_q;
    rx_d      = rx_q;
    cx_d      = cx_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    base_d    = base_q;
    kb_d      = kb_q;
    dim_err_d = dim_err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        rw_d      = bus.row_w;
        cw_d      = bus.col_w;
        rx_d      = bus.row_x;
        cx_d      = bus.col_x;
        dim_err_d = bad;
        state_d   = bad ? IDLE : LOAD_W;
        r_d       = '0;
        c_d       = '0;
        base_d    = '0;
      end
      LOAD_W, LOAD_X: if (beat) begin
        c_d    = last_c ? '0 : c_q + 1'b1;
        r_d    = last_c ? r_q + 1'b1 : r_q;
        base_d = last_c ? base_q + AW'(MAX_DIM) : base_q;
        if (last_c && last_r) begin
          r_d     = '0;
          base_d  = '0;
          state_d = (state_q == LOAD_W) ? LOAD_X : CLR;
        end
      end
      CLR: begin
        k_d     = '0;
        kb_d    = '0;
        state_d = STREAM;
      end
      STREAM: if (!bus.hold) begin
        k_d     = k_q + 1'b1;
        kb_d    = kb_q + AW'(MAX_DIM);
        state_d = (k_q == cw_q - 1'b1) ? DONE : STREAM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      rw_q      <= '0;
      cw_q      <= '0;
      rx_q      <= '0;
      cx_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      base_q    <= '0;
      kb_q      <= '0;
      dim_err_q <= 1'b0;
      for (int n = 0; n < N; n++) begin
        w_q[n] <= '0;
        x_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      cw_q      <= cw_d;
      rx_q      <= rx_d;
      cx_q      <= cx_d;
      r_q       <= r_d;
      c_q       <= c_d;
      k_q       <= k_d;
      base_q    <= base_d;
      kb_q      <= kb_d;
      dim_err_q <= dim_err_d;
      if (beat && state_q == LOAD_W) w_q[addr] <= bus.data_in;
      if (beat && state_q == LOAD_X) x_q[addr] <= bus.data_in;
    end
  end
  assign bus.in_ready = (state_q == LOAD_W) || (state_q == LOAD_X);
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = state_q == DONE;
  assign bus.dim_err  = dim_err_q;
  // Lanes and cells outside the latched dimensions are forced to zero.
  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    assign bus.w_out[i*DW +: DW] = (streaming && DIMW'(i) < rw_q) ? w_q[AW'(i*MAX_DIM) + AW'(k_q)] : '0;
    assign bus.x_out[i*DW +: DW] = (streaming && DIMW'(i) < cx_q) ? x_q[kb_q + AW'(i)] : '0;
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_cell
      logic act;
      assign act = (DIMW'(i) < rw_q) && (DIMW'(j) < cx_q);
      assign bus.ld_mac[i*MAX_DIM+j]    = streaming && act;
      assign bus.clear_mac[i*MAX_DIM+j] = (state_q == CLR) && act;
    end
  end
endmodule

// File: tb/tb_operand_stream_bank.sv
// tb_operand_stream_bank: directed vectors with hand-computed lanes, strobes and done timing.
module tb_operand_stream_bank;
  localparam int DW = 4, MD = 3, DIMW = 2;
  logic clk = 1'b0, clear = 1'b1;
  int cyc = 0, t0 = 0, checks = 0, errors = 0;
  logic [3:0]  src [18];
  logic [11:0] ew [3], ex [3];
  logic [8:0]  el;
  operand_stream_bank_if #(.DW(DW), .MAX_DIM(MD)) bus();
  operand_stream_bank #(.DW(DW), .MAX_DIM(MD)) dut (.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_start(input int rw, input int cw, input int rx, input int cx);
    @(negedge clk);
    bus.start = 1'b1;
    bus.row_w = DIMW'(rw);
    bus.col_w = DIMW'(cw);
    bus.row_x = DIMW'(rx);
    bus.col_x = DIMW'(cx);
    @(posedge clk);
    #1 t0 = cyc;
    bus.start = 1'b0;
  endtask
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.data_in  = src[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic watch(input int hk, input int hn, input logic [8:0] exp_clr, input int nexp, input int dexp);
    int nb = 0, held = 0, dc = -1;
    chk("clear_mac", bus.clear_mac, exp_clr);
    chk("clr_in_ready", bus.in_ready, 0);
    for (int t = 0; t < 60 && dc < 0; t++) begin
      @(posedge clk);
      #1 bus.hold = (nb == hk) && (held < hn);
      @(negedge clk);
      if (bus.done) dc = cyc - t0;
      else if (bus.hold) begin
        chk("hold_w", bus.w_out, 0);
        chk("hold_x", bus.x_out, 0);
        chk("hold_ld", bus.ld_mac, 0);
        held++;
      end else if (nb < nexp) begin
        chk($sformatf("w_k%0d", nb), bus.w_out, ew[nb]);
        chk($sformatf("x_k%0d", nb), bus.x_out, ex[nb]);
        chk($sformatf("ld_k%0d", nb), bus.ld_mac, el);
        nb++;
      end else chk("extra_beat_ld", bus.ld_mac, 0);
    end
    bus.hold = 1'b0;
    chk("done_cycle", dc, dexp);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask
  task automatic set_3x3();
    for (int i = 0; i < 9; i++) begin
      src[i]   = 4'(i + 1);
      src[9+i] = 4'(9 - i);
    end
    ew = '{12'h741, 12'h852, 12'h963};
    ex = '{12'h789, 12'h456, 12'h123};
    el = 9'h1FF;
  endtask
  initial begin
    bus.start = 1'b0; bus.row_w = '0; bus.col_w = '0; bus.row_x = '0; bus.col_x = '0;
    bus.data_in = '0; bus.in_valid = 1'b0; bus.hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_w_out", bus.w_out, 0);
    chk("rst_x_out", bus.x_out, 0);
    chk("rst_ld_mac", bus.ld_mac, 0);
    chk("rst_clear_mac", bus.clear_mac, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dim_err", bus.dim_err, 0);
    clear = 1'b0;
    set_3x3();
    do_start(3, 3, 3, 3);
    chk("start_busy", bus.busy, 1);
    feed(18, 1'b0);
    watch(-1, 0, 9'h1FF, 3, 22);
    do_start(3, 3, 3, 3);
    feed(18, 1'b0);
    watch(1, 2, 9'h1FF, 3, 24);
    for (int i = 0; i < 9; i++) src[i] = 4'(i + 1);
    ew = '{12'h041, 12'h052, 12'h063};
    ex = '{12'h007, 12'h008, 12'h009};
    el = 9'h009;
    do_start(2, 3, 3, 1);
    feed(9, 1'b0);
    watch(-1, 0, 9'h009, 3, 13);
    do_start(3, 2, 3, 3);
    @(negedge clk);
    chk("mismatch_dim_err", bus.dim_err, 1);
    chk("mismatch_busy", bus.busy, 0);
    chk("mismatch_in_ready", bus.in_ready, 0);
    do_start(4, 3, 3, 3);
    @(negedge clk);
    chk("oversize_dim_err", bus.dim_err, 1);
    chk("oversize_busy", bus.busy, 0);
    set_3x3();
    do_start(3, 3, 3, 3);
    chk("dim_err_cleared", bus.dim_err, 0);
    feed(18, 1'b1);
    watch(-1, 0, 9'h1FF, 3, 40);
    for (int i = 0; i < 9; i++) src[i] = 4'hF;
    do_start(3, 3, 3, 3);
    feed(5, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", bus.busy, 0);
    chk("clr_in_ready", bus.in_ready, 0);
    chk("clr_w_out", bus.w_out, 0);
    chk("clr_x_out", bus.x_out, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_dim_err", bus.dim_err, 0);
    for (int i = 0; i < 8; i++) src[i] = 4'(i + 1);
    ew = '{12'h031, 12'h042, 12'h000};
    ex = '{12'h065, 12'h087, 12'h000};
    el = 9'h01B;
    do_start(2, 2, 2, 2);
    feed(8, 1'b0);
    watch(-1, 0, 9'h01B, 2, 11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
